// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver state encoding and parity mode constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // 2'b11 is treated as no parity, same as PAR_NONE
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// rtl/uart_bit_sampler.sv - rx synchronizer and three-sample majority voter
module uart_bit_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int S_W        = $clog2(OVERSAMPLE)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_tick,
    input  logic           rx,
    input  logic [S_W-1:0] s,
    output logic           rx_sync,
    output logic           vote
);

    localparam int MID = OVERSAMPLE / 2;

    logic [1:0] sync_q, sync_d;
    logic [1:0] samp_q, samp_d;

    // The first two samples are stored; the third is the live value, so vote
    // is only meaningful on the tick where s == MID+1.
    always_comb begin
        sync_d = {sync_q[0], rx};
        samp_d = samp_q;
        if (s_tick && ((s == S_W'(MID - 1)) || (s == S_W'(MID))))
            samp_d = {samp_q[0], sync_q[1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            samp_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
            samp_q <= samp_d;
        end
    end

    assign rx_sync = sync_q[1];
    assign vote    = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_sync) | (samp_q[0] & rx_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - oversampled UART receiver with runtime parity/stop config
module uart_rx_cfg import uart_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_tick,
    input  logic                  rx,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun,
    output logic                  busy
);

    localparam int S_W  = $clog2(OVERSAMPLE);
    localparam int BI_W = $clog2(DATA_WIDTH);
    localparam logic [S_W-1:0] S_VOTE = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);

    rx_state_e             state_q, state_d;
    logic [S_W-1:0]        s_q, s_d, s_next;
    logic [BI_W-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [1:0]            par_mode_q, par_mode_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  par_vote_q, par_vote_d;
    logic                  stop0_q, stop0_d;
    logic                  brk_hold_q, brk_hold_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
    logic                  ovr_q, ovr_d;

    logic rx_sync, vote, tick_vote, tick_last;
    logic commit, first_stop, data_par, c_perr, c_ferr, c_brk;

    uart_bit_sampler #(.OVERSAMPLE(OVERSAMPLE), .S_W(S_W)) u_sampler (
        .clk     (clk),
        .reset   (reset),
        .s_tick  (s_tick),
        .rx      (rx),
        .s       (s_q),
        .rx_sync (rx_sync),
        .vote    (vote)
    );

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_mode_d = par_mode_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        par_vote_d = par_vote_q;
        stop0_d    = stop0_q;
        brk_hold_d = brk_hold_q;
        commit     = 1'b0;
        tick_vote  = s_tick && (s_q == S_VOTE);
        tick_last  = s_tick && (s_q == S_LAST);
        s_next     = tick_last ? '0 : (s_tick ? s_q + S_W'(1) : s_q);
        s_d        = s_next;

        first_stop = (stop_idx_q == 1'b0) ? vote : stop0_q;
        data_par   = (^shreg_q) ^ par_vote_q;
        c_ferr     = ~vote | ~first_stop;
        c_brk      = (shreg_q == '0) && !(parity_enabled(par_mode_q) && par_vote_q) && !first_stop;
        if (par_mode_q == PAR_EVEN)     c_perr = data_par;
        else if (par_mode_q == PAR_ODD) c_perr = ~data_par;
        else                            c_perr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                s_d = '0;
                // A break keeps the line low; wait for it to return high first.
                if (brk_hold_q) begin
                    if (rx_sync) brk_hold_d = 1'b0;
                end else if (!rx_sync) begin
                    state_d    = ST_START;
                    bit_d      = '0;
                    shreg_d    = '0;
                    stop_idx_d = 1'b0;
                    par_mode_d = cfg_parity;
                    stop2_d    = cfg_stop2;
                end
            end
            ST_START: begin
                if (tick_vote && vote) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                end else if (tick_last) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_vote) shreg_d = {vote, shreg_q[DATA_WIDTH-1:1]};
                if (tick_last) begin
                    if (bit_q == BI_W'(DATA_WIDTH - 1))
                        state_d = parity_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
                    else
                        bit_d = bit_q + BI_W'(1);
                end
            end
            ST_PARITY: begin
                if (tick_vote) par_vote_d = vote;
                if (tick_last) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick_vote) begin
                    if (stop_idx_q == 1'b0) stop0_d = vote;
                    // Commit mid-bit so the next start edge is caught in IDLE.
                    if (stop_idx_q == stop2_q) begin
                        commit     = 1'b1;
                        state_d    = ST_IDLE;
                        s_d        = '0;
                        brk_hold_d = c_brk;
                    end
                end
                if (tick_last) stop_idx_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
            end
        endcase
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        ovr_d   = 1'b0;
        if (commit) begin
            if (!valid_q || dout_ready) begin
                dout_d  = shreg_q;
                perr_d  = c_perr;
                ferr_d  = c_ferr;
                brk_d   = c_brk;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_mode_q <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            par_vote_q <= 1'b0;
            stop0_q    <= 1'b0;
            brk_hold_q <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_mode_q <= par_mode_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            par_vote_q <= par_vote_d;
            stop0_q    <= stop0_d;
            brk_hold_q <= brk_hold_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign break_det  = brk_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed scoreboard bench for uart_rx_cfg
module tb_uart_rx_cfg;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = 16 * TICK_DIV;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick = 1'b0;
    logic       rx;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       parity_err, frame_err, break_det, overrun, busy;

    int   total = 0;
    int   bad   = 0;
    int   ovr_cnt = 0;
    int   busy_cnt = 0;
    int   ovr_snap, busy_snap;
    exp_t sb[$];

    uart_rx_cfg dut (
        .clk        (clk),
        .reset      (reset),
        .s_tick     (s_tick),
        .rx         (rx),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .break_det  (break_det),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            s_tick = (cnt == TICK_DIV - 1);
            cnt = (cnt + 1) % TICK_DIV;
        end
    end

    always @(negedge clk) begin
        if (overrun) ovr_cnt = ovr_cnt + 1;
        if (busy)    busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pb,
                              input logic two_stop, input logic stop2_val, input int stop2_clks);
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLK);
        if (par_en) send_bit(pb, BIT_CLK);
        send_bit(1'b1, BIT_CLK);
        if (two_stop) send_bit(stop2_val, stop2_clks);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (dout_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(dout_valid), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_dout"}, 32'(dout), 32'(e.d));
            chk({tag, "_perr"}, 32'(parity_err), 32'(e.pe));
            chk({tag, "_ferr"}, 32'(frame_err), 32'(e.fe));
            chk({tag, "_brk"},  32'(break_det), 32'(e.bk));
        end
    endtask

    task automatic consume(input string tag);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_cleared"}, 32'(dout_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        rx = 1'b1;
        reset = 1'b1;
        dout_ready = 1'b0;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_flags", {29'd0, parity_err, frame_err, break_det}, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // plain 8N1 frame held while not ready
        sb.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0, bk: 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        wait_valid("a5_valid");
        check_frame("a5");
        repeat (100) @(negedge clk);
        chk("a5_hold_valid", 32'(dout_valid), 32'd1);
        chk("a5_hold_dout", 32'(dout), 32'hA5);
        consume("a5");
        repeat (BIT_CLK) @(negedge clk);

        // even parity, both parity bit values
        cfg_parity = 2'b01;
        d = 8'h37;
        for (int pb = 0; pb < 2; pb++) begin
            sb.push_back('{d: d, pe: (^d) ^ pb[0], fe: 1'b0, bk: 1'b0});
            send_frame(d, 1'b1, pb[0], 1'b0, 1'b1, 0);
            wait_valid("par_valid");
            check_frame(pb == 0 ? "par0" : "par1");
            consume("par");
            repeat (BIT_CLK) @(negedge clk);
        end

        // two stop bits, second one low (cut short so no real start follows)
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b1;
        sb.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b1, bk: 1'b0});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 3 * BIT_CLK / 4);
        wait_valid("stop2_valid");
        check_frame("stop2");
        consume("stop2");
        cfg_stop2 = 1'b0;
        repeat (2 * BIT_CLK) @(negedge clk);

        // false start: low for 3 ticks
        busy_snap = busy_cnt;
        send_bit(1'b0, 3 * TICK_DIV);
        send_bit(1'b1, 2 * BIT_CLK);
        chk("fs_busy_seen", 32'(busy_cnt > busy_snap), 32'd1);
        chk("fs_idle", 32'(busy), 32'd0);
        chk("fs_no_valid", 32'(dout_valid), 32'd0);

        // back-to-back frames with no consumer
        ovr_snap = ovr_cnt;
        sb.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0, bk: 1'b0});
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        repeat (BIT_CLK) @(negedge clk);
        chk("b2b_overrun_once", 32'(ovr_cnt - ovr_snap), 32'd1);
        wait_valid("b2b_valid");
        check_frame("b2b");
        consume("b2b");
        repeat (BIT_CLK) @(negedge clk);

        // break: line low for 12 bit times
        sb.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, bk: 1'b1});
        send_bit(1'b0, 11 * BIT_CLK);
        chk("brk_hold_idle", 32'(busy), 32'd0);
        send_bit(1'b0, BIT_CLK);
        wait_valid("brk_valid");
        check_frame("brk");
        consume("brk");
        send_bit(1'b1, 2 * BIT_CLK);
        sb.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0, bk: 1'b0});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        wait_valid("post_brk_valid");
        check_frame("post_brk");
        consume("post_brk");
        repeat (BIT_CLK) @(negedge clk);

        // reset in the middle of a frame
        send_bit(1'b0, BIT_CLK);
        send_bit(1'b0, 3 * BIT_CLK);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (12 * BIT_CLK) @(negedge clk);
        chk("mid_rst_no_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_idle", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
